bus_arbiter: RTL

- Central arbiter for the shared 38-bit memory bus (6-bit header {proc ID, PID, op} plus 32-bit data).
- Collects bus_req/bus_req_type/bus_req_clc from every bus agent: the DRAM controller and the per-core caches.
- Grants exactly one agent per tenure and holds the grant for the requested number of bus cycles.
- Drives the bus_grant and bus_active inputs that the DRAM controller and caches consume.

---
 rtl/bus_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: central arbiter for the shared 38-bit memory bus.
//
// Grants exactly one agent per tenure and holds the grant for the number of
// bus cycles that agent requested. High-class requests (responses and
// write-backs) beat low-class requests. Within a class, a shared round-robin
// pointer picks the first requester at or after the pointer. Each tenure is
// followed by one turnaround cycle with no grant.
//
// Ports:
//   plusclk      system clock, rising edge
//   rst          asynchronous reset, active low
//   req          per-agent request level (agent 0 is the DRAM controller)
//   req_type     per-agent class: 1 = response/write-back, 0 = new request
//   req_clc      per-agent tenure length, agent i at [i*CLC_WIDTH +: CLC_WIDTH]
//   bus_grant    registered one-hot grant
//   bus_active   registered, high for every cycle of a tenure
//   grant_id     index of the current or last granted agent
//   tenure_left  cycles remaining in the current tenure, 0 when idle
module bus_arbiter #(
    parameter int NUM_AGENTS = 4,
    parameter int ID_WIDTH   = 2,
    parameter int CLC_WIDTH  = 6
) (
    input  logic                            plusclk,
    input  logic                            rst,
    input  logic [NUM_AGENTS-1:0]           req,
    input  logic [NUM_AGENTS-1:0]           req_type,
    input  logic [NUM_AGENTS*CLC_WIDTH-1:0] req_clc,
    output logic [NUM_AGENTS-1:0]           bus_grant,
    output logic                            bus_active,
    output logic [ID_WIDTH-1:0]             grant_id,
    output logic [CLC_WIDTH-1:0]            tenure_left
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [ID_WIDTH-1:0]   ptr;
    logic [ID_WIDTH-1:0]   ptr_nxt;
    logic [NUM_AGENTS-1:0] grant_nxt;
    logic                  active_nxt;
    logic [ID_WIDTH-1:0]   id_nxt;
    logic [CLC_WIDTH-1:0]  left_nxt;

    logic [NUM_AGENTS-1:0] high_req;
    logic [NUM_AGENTS-1:0] cand;
    logic                  win_found;
    logic [ID_WIDTH-1:0]   win_idx;
    logic [ID_WIDTH-1:0]   idx;
    logic [CLC_WIDTH-1:0]  win_clc;

    // Winner selection: restrict to the high class when any high-class
    // request is present, then scan upward from the pointer with wrap.
    always_comb begin
        high_req  = req & req_type;
        cand      = (|high_req) ? high_req : req;
        win_found = 1'b0;
        win_idx   = '0;
        win_clc   = '0;
        idx       = '0;
        for (int k = 0; k < NUM_AGENTS; k++) begin
            idx = ID_WIDTH'((int'(ptr) + k) % NUM_AGENTS);
            if (!win_found && cand[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
                win_clc   = req_clc[int'(idx)*CLC_WIDTH +: CLC_WIDTH];
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        grant_nxt  = bus_grant;
        active_nxt = bus_active;
        id_nxt     = grant_id;
        left_nxt   = tenure_left;
        case (state)
            // The turnaround cycle itself is the one idle cycle between
            // tenures, so requests are also arbitrated on its closing edge.
            IDLE, TURN: begin
                state_nxt  = IDLE;
                grant_nxt  = '0;
                active_nxt = 1'b0;
                left_nxt   = '0;
                if (win_found) begin
                    state_nxt  = GRANT;
                    grant_nxt  = NUM_AGENTS'(1) << win_idx;
                    active_nxt = 1'b1;
                    id_nxt     = win_idx;
                    // A zero-length request still gets one bus cycle.
                    left_nxt   = (win_clc == '0) ? CLC_WIDTH'(1) : win_clc;
                    ptr_nxt    = (win_idx == ID_WIDTH'(NUM_AGENTS - 1)) ?
                                 '0 : win_idx + 1'b1;
                end
            end
            GRANT: begin
                if (tenure_left <= CLC_WIDTH'(1)) begin
                    state_nxt  = TURN;
                    grant_nxt  = '0;
                    active_nxt = 1'b0;
                    left_nxt   = '0;
                end else begin
                    left_nxt = tenure_left - 1'b1;
                end
            end
            default: begin
                state_nxt  = IDLE;
                grant_nxt  = '0;
                active_nxt = 1'b0;
                left_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge plusclk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            ptr         <= '0;
            bus_grant   <= '0;
            bus_active  <= 1'b0;
            grant_id    <= '0;
            tenure_left <= '0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            bus_grant   <= grant_nxt;
            bus_active  <= active_nxt;
            grant_id    <= id_nxt;
            tenure_left <= left_nxt;
        end
    end

endmodule
